// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined 3:2 carry-save adder tree with a registered final add and valid/ready handshake.
// Define CSA_TREE_SIGNED_EN to treat operands and result as two's complement (sign-extended operands).
module csa_tree_pipe #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 8,
  localparam int OUT_W = DATA_W + $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_sum
);

  function automatic int unsigned cnt_at(input int unsigned lvl);
    int unsigned n = N_IN;
    for (int unsigned i = 0; i < lvl; i++) n = n - n / 3;
    return n;
  endfunction

  function automatic int unsigned calc_levels();
    int unsigned n = N_IN;
    int unsigned l = 0;
    while (n > 2) begin
      n = n - n / 3;
      l++;
    end
    return l;
  endfunction

  localparam int unsigned LEVELS = calc_levels();

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv | rst;

  logic [OUT_W-1:0] ext [N_IN];
  for (genvar k = 0; k < N_IN; k++) begin : g_ext
`ifdef CSA_TREE_SIGNED_EN
    assign ext[k] = {{(OUT_W-DATA_W){in_data[k*DATA_W+DATA_W-1]}}, in_data[k*DATA_W +: DATA_W]};
`else
    assign ext[k] = {{(OUT_W-DATA_W){1'b0}}, in_data[k*DATA_W +: DATA_W]};
`endif
  end

  // Level l reduces N words to N - N/3: sum/carry pairs first, leftovers appended in index order.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned N = cnt_at(l);
    localparam int unsigned T = N / 3;
    localparam int unsigned M = N - T;

    logic             vin;
    logic             vld;
    logic [OUT_W-1:0] src [N];
    logic [OUT_W-1:0] nxt [M];
    logic [OUT_W-1:0] stg [M];

    if (l == 0) begin : g_head
      assign vin = in_valid;
      for (genvar k = 0; k < N; k++) begin : g_src
        assign src[k] = ext[k];
      end
    end else begin : g_body
      assign vin = g_lvl[l-1].vld;
      for (genvar k = 0; k < N; k++) begin : g_src
        assign src[k] = g_lvl[l-1].stg[k];
      end
    end

    for (genvar j = 0; j < T; j++) begin : g_csa
      assign nxt[2*j]   = src[3*j] ^ src[3*j+1] ^ src[3*j+2];
      assign nxt[2*j+1] = ((src[3*j] & src[3*j+1]) | (src[3*j] & src[3*j+2])
                          | (src[3*j+1] & src[3*j+2])) << 1;
    end

    for (genvar r = 0; r < N - 3*T; r++) begin : g_pass
      assign nxt[2*T+r] = src[3*T+r];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= 1'b0;
        stg <= '{default: '0};
      end else if (adv) begin
        vld <= vin;
        stg <= nxt;
      end
    end
  end

  logic [OUT_W-1:0] fin_a;
  logic [OUT_W-1:0] fin_b;
  logic             fin_v;

  if (LEVELS == 0) begin : g_direct
    assign fin_a = ext[0];
    assign fin_b = ext[1];
    assign fin_v = in_valid;
  end else begin : g_tail
    assign fin_a = g_lvl[LEVELS-1].stg[0];
    assign fin_b = g_lvl[LEVELS-1].stg[1];
    assign fin_v = g_lvl[LEVELS-1].vld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (adv) begin
      out_valid <= fin_v;
      out_sum   <= fin_a + fin_b;
    end
  end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Scoreboard bench for csa_tree_pipe: main 8x8 instance plus small N_IN=2 and N_IN=3 instances.
module tb_csa_tree_pipe;
  localparam int DW = 8;
  localparam int NI = 8;
  localparam int OW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [NI*DW-1:0] in_data;
  logic [OW-1:0]  out_sum;

  logic           s2_iv, s2_ir, s2_ov;
  logic [7:0]     s2_d;
  logic [4:0]     s2_sum;
  logic           s3_iv, s3_ir, s3_ov;
  logic [23:0]    s3_d;
  logic [9:0]     s3_sum;
  logic           s_rdy;

  csa_tree_pipe #(.DATA_W(DW), .N_IN(NI)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  csa_tree_pipe #(.DATA_W(4), .N_IN(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(s2_iv), .in_ready(s2_ir), .in_data(s2_d),
    .out_valid(s2_ov), .out_ready(s_rdy), .out_sum(s2_sum)
  );

  csa_tree_pipe #(.DATA_W(8), .N_IN(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(s3_iv), .in_ready(s3_ir), .in_data(s3_d),
    .out_valid(s3_ov), .out_ready(s_rdy), .out_sum(s3_sum)
  );

  typedef struct {
    logic [OW-1:0] sum;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];
  exp_t sb3[$];
  int   pop_cyc[$];
  exp_t e, e2, e3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;
  int n2 = 0;
  int n3 = 0;
  logic [OW-1:0] exp_cur;
  bit            lat_cur;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Scoreboard push on every accepted input; reset discards everything in flight.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      sb2.delete();
      sb3.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back('{sum: exp_cur, cyc: cyc, lat: lat_cur});
      if (s2_iv && s2_ir) sb2.push_back('{sum: 11'd30, cyc: cyc, lat: 1'b1});
      if (s3_iv && s3_ir) sb3.push_back('{sum: 11'd7, cyc: cyc, lat: 1'b1});
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got out_sum=%0d with no vector pending", out_sum);
      end else begin
        e = sb.pop_front();
        check("sum", 32'(out_sum), 32'(e.sum));
        if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd5);
      end
    end
    if (s2_ov) begin
      n2++;
      if (sb2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out2: got %0d with no vector pending", s2_sum);
      end else begin
        e2 = sb2.pop_front();
        check("sum_n2", 32'(s2_sum), 32'(e2.sum));
        check("latency_n2", 32'(cyc - e2.cyc), 32'd1);
      end
    end
    if (s3_ov) begin
      n3++;
      if (sb3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out3: got %0d with no vector pending", s3_sum);
      end else begin
        e3 = sb3.pop_front();
        check("sum_n3", 32'(s3_sum), 32'(e3.sum));
        check("latency_n3", 32'(cyc - e3.cyc), 32'd2);
      end
    end
  end

  function automatic logic [63:0] ramp(input int s);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(s + k);
    return v;
  endfunction

  task automatic send(input logic [63:0] d, input logic [OW-1:0] want, input bit lat);
    bit done;
    done     = 1'b0;
    in_data  = d;
    exp_cur  = want;
    lat_cur  = lat;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      if (in_ready && !rst) done = 1'b1;
    end
    #1;
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no acceptance expected in_ready within 60 cycles");
    end
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) idle = 1'b1;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s2_iv = 1'b0; s2_d = '0; s3_iv = 1'b0; s3_d = '0; s_rdy = 1'b1;
    exp_cur = '0; lat_cur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // all 0xFF: 2040 unsigned, -8 signed; both are 11'h7F8
    send({8{8'hFF}}, 11'h7F8, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("ff_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("ff_then_low", 32'(out_valid), 32'd0);
    drain();

    // back-to-back vectors, results on consecutive cycles
    pop_cyc.delete();
    send(ramp(1), 11'd36, 1'b1);
    send(ramp(0), 11'd28, 1'b1);
    send(ramp(2), 11'd44, 1'b1);
    drain();
    check("b2b_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check("b2b_gap1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
    end

    // stall with a full pipeline
    p0 = pops;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 7; i++) send(ramp(i), 11'(28 + 8 * i), 1'b0);
      end
    join_none
    repeat (8) @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_hold_sum", 32'(out_sum), 32'd28);
      check("stall_hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;
    drain();
    check("stall_count", 32'(pops - p0), 32'd7);

    // reset with three vectors in flight
    send(ramp(10), 11'd108, 1'b0);
    send(ramp(20), 11'd188, 1'b0);
    send(ramp(30), 11'd268, 1'b0);
    rst = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sum", 32'(out_sum), 32'd0);
    p0 = pops;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_emit", 32'(pops - p0), 32'd0);
    send({8{8'h05}}, 11'd40, 1'b1);
    drain();

    // 0x80 x8: 1024 unsigned, -1024 signed; both 11'h400
    send({8{8'h80}}, 11'h400, 1'b1);
`ifdef CSA_TREE_SIGNED_EN
    send({{4{8'h80}}, {4{8'h7F}}}, 11'h7FC, 1'b1);
`else
    send({{4{8'h80}}, {4{8'h7F}}}, 11'h3FC, 1'b1);
`endif
    drain();

    // small instances: 15+15=30 (latency 1), 1+2+4=7 (latency 2)
    s2_d = {4'hF, 4'hF};
    s3_d = {8'd4, 8'd2, 8'd1};
    s2_iv = 1'b1;
    s3_iv = 1'b1;
    @(posedge clk);
    #1;
    s2_iv = 1'b0;
    s3_iv = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("n2_count", 32'(n2), 32'd1);
    check("n3_count", 32'(n3), 32'd1);

    check("final_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
